image_load_ctrl: RTL and testbench

Sequencer that drives the SD-card file reader and turns its byte stream into pixel writes for the frame buffer. It holds the reader in reset, releases it, skips a fixed file header, packs every three bytes into a 24-bit RGB pixel and issues one linear-address write per pixel. It sits in the `clk_50` domain, between `sd_file_reader` and the frame-buffer write port. The HDMI side reads the frame buffer independently.

---
 rtl/image_load_ctrl.sv | 157 +++++++++++++++
 tb/tb_image_load_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/image_load_ctrl.sv
// image_load_ctrl: sequences the SD-card file reader through reset, header skip
// and RGB byte packing, and issues one linear-address frame-buffer write per pixel.
module image_load_ctrl #(
    parameter int IMG_WIDTH    = 640,
    parameter int IMG_HEIGHT   = 480,
    parameter int HEADER_BYTES = 54,
    parameter int RST_CYCLES   = 16,
    parameter int ADDR_W       = 19
) (
    input  logic              clk_50,
    input  logic              rst_in,
    input  logic              start,
    output logic              sd_rst_n,
    input  logic              file_found,
    input  logic [2:0]        fatstate,
    input  logic              outreq,
    input  logic [7:0]        outbyte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [23:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int HDR_W = (HEADER_BYTES > 1) ? $clog2(HEADER_BYTES) : 1;

    localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [HDR_W-1:0]  HDR_LAST = HDR_W'((HEADER_BYTES > 0) ? HEADER_BYTES - 1 : 0);
    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [2:0]        FAT_DONE = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SD_RST,
        ST_SKIP_HDR,
        ST_PIXEL,
        ST_DONE,
        ST_ERROR
    } state_t;

    state_t             state;
    logic [RST_W-1:0]   rst_cnt;
    logic [HDR_W-1:0]   hdr_cnt;
    logic [1:0]         phase;
    logic [ADDR_W-1:0]  pix_cnt;
    logic [7:0]         r_byte;
    logic [7:0]         g_byte;
    logic               fail;

    // The reader reports DONE either without having found the file, or with no byte
    // pending, which while still loading means the file ended early.
    assign fail = (fatstate == FAT_DONE) && (!file_found || !outreq);

    // Load sequencer: start restarts from any state; all outputs are registered here.
    always_ff @(posedge clk_50 or posedge rst_in) begin
        if (rst_in) begin
            state    <= ST_IDLE;
            rst_cnt  <= '0;
            hdr_cnt  <= '0;
            phase    <= '0;
            pix_cnt  <= '0;
            r_byte   <= '0;
            g_byte   <= '0;
            sd_rst_n <= 1'b0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                state    <= ST_SD_RST;
                rst_cnt  <= '0;
                hdr_cnt  <= '0;
                phase    <= '0;
                pix_cnt  <= '0;
                sd_rst_n <= 1'b0;
                busy     <= 1'b1;
                done     <= 1'b0;
                error    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        sd_rst_n <= 1'b0;
                    end
                    ST_SD_RST: begin
                        if (rst_cnt == RST_LAST) begin
                            sd_rst_n <= 1'b1;
                            if (HEADER_BYTES == 0) begin
                                state <= ST_PIXEL;
                            end else begin
                                state <= ST_SKIP_HDR;
                            end
                        end else begin
                            rst_cnt <= rst_cnt + 1'b1;
                        end
                    end
                    ST_SKIP_HDR: begin
                        if (fail) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else if (outreq) begin
                            if (hdr_cnt == HDR_LAST) begin
                                state <= ST_PIXEL;
                            end else begin
                                hdr_cnt <= hdr_cnt + 1'b1;
                            end
                        end
                    end
                    ST_PIXEL: begin
                        if (fail) begin
                            state <= ST_ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else if (outreq) begin
                            case (phase)
                                2'd0: begin
                                    r_byte <= outbyte;
                                    phase  <= 2'd1;
                                end
                                2'd1: begin
                                    g_byte <= outbyte;
                                    phase  <= 2'd2;
                                end
                                default: begin
                                    wr_en   <= 1'b1;
                                    wr_data <= {r_byte, g_byte, outbyte};
                                    wr_addr <= pix_cnt;
                                    pix_cnt <= pix_cnt + 1'b1;
                                    phase   <= 2'd0;
                                    if (pix_cnt == PIX_LAST) begin
                                        state <= ST_DONE;
                                        done  <= 1'b1;
                                        busy  <= 1'b0;
                                    end
                                end
                            endcase
                        end
                    end
                    ST_DONE: begin
                    end
                    ST_ERROR: begin
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_image_load_ctrl.sv
// tb_image_load_ctrl: directed scenarios for image_load_ctrl with small image
// parameters; each task drives one scenario and checks against hand-computed values.
module tb_image_load_ctrl;

    localparam int IW = 4;
    localparam int IH = 2;
    localparam int HB = 2;
    localparam int RC = 4;
    localparam int AW = 3;

    logic          clk_50;
    logic          rst_in;
    logic          start;
    logic          sd_rst_n;
    logic          file_found;
    logic [2:0]    fatstate;
    logic          outreq;
    logic [7:0]    outbyte;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [23:0]   wr_data;
    logic          busy;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] wa_q[$];
    logic [23:0]   wd_q[$];
    logic          wdone_q[$];

    image_load_ctrl #(
        .IMG_WIDTH    (IW),
        .IMG_HEIGHT   (IH),
        .HEADER_BYTES (HB),
        .RST_CYCLES   (RC),
        .ADDR_W       (AW)
    ) dut (
        .clk_50     (clk_50),
        .rst_in     (rst_in),
        .start      (start),
        .sd_rst_n   (sd_rst_n),
        .file_found (file_found),
        .fatstate   (fatstate),
        .outreq     (outreq),
        .outbyte    (outbyte),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    // 100 MHz-style free-running clock
    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    // Collect every frame-buffer write, sampled away from the active edge
    always @(negedge clk_50) begin
        if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
            wdone_q.push_back(done);
        end
    end

    // Hard stop in case something stalls the sequence
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic cycle();
        @(posedge clk_50);
        #1;
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
        wdone_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        outreq  = 1'b1;
        outbyte = b;
        cycle();
        outreq  = 1'b0;
    endtask

    task automatic wait_release(output int low);
        low = 0;
        while (sd_rst_n !== 1'b1 && low < 100) begin
            low++;
            cycle();
        end
    endtask

    task automatic start_load(output int low);
        start = 1'b1;
        cycle();
        start = 1'b0;
        wait_release(low);
    endtask

    function automatic logic [23:0] pix(input int i);
        pix = {8'(3 * i), 8'(3 * i + 1), 8'(3 * i + 2)};
    endfunction

    task automatic test_reset();
        int bad;
        rst_in = 1'b1;
        repeat (3) cycle();
        checks++;
        if ({sd_rst_n, wr_en, busy, done, error} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("[TB] FAIL reset_values: got sd_rst_n=%b wr_en=%b busy=%b done=%b error=%b addr=%0d data=%h, expected all 0",
                     sd_rst_n, wr_en, busy, done, error, wr_addr, wr_data);
        end
        rst_in = 1'b0;
        clear_writes();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            outreq  = 1'($urandom_range(0, 1));
            outbyte = 8'($urandom_range(0, 255));
            cycle();
            if ({sd_rst_n, busy, done, error} !== 4'b0 || wr_addr !== '0 || wr_data !== '0) bad++;
        end
        outreq = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("[TB] FAIL idle_outputs: got %0d cycles with non-reset outputs, expected 0", bad);
        end
        checks++;
        if (wa_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL idle_writes: got %0d writes, expected 0", wa_q.size());
        end
    endtask

    task automatic test_full_load();
        int low;
        clear_writes();
        start_load(low);
        checks++;
        if (low != RC) begin
            errors++;
            $display("[TB] FAIL full_rst_low: got %0d cycles, expected %0d", low, RC);
        end
        send_byte(8'hEE);
        send_byte(8'hEE);
        for (int i = 0; i < 24; i++) send_byte(8'(i));
        checks++;
        if ({wr_en, done, busy} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL full_last_write: got wr_en=%b done=%b busy=%b, expected 1 1 0", wr_en, done, busy);
        end
        cycle();
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 3'd7 || wr_data !== 24'h151617 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_hold: got wr_en=%b addr=%0d data=%h done=%b, expected 0 7 151617 1",
                     wr_en, wr_addr, wr_data, done);
        end
        checks++;
        if (wa_q.size() != 8) begin
            errors++;
            $display("[TB] FAIL full_count: got %0d writes, expected 8", wa_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== pix(i) || wdone_q[i] !== (i == 7)) begin
                    errors++;
                    $display("[TB] FAIL full_write%0d: got addr=%0d data=%h done=%b, expected %0d %h %b",
                             i, wa_q[i], wd_q[i], wdone_q[i], i, pix(i), (i == 7));
                end
            end
        end
    endtask

    task automatic test_gapped();
        int low;
        clear_writes();
        start_load(low);
        checks++;
        if (low != RC) begin
            errors++;
            $display("[TB] FAIL gap_rst_low: got %0d cycles, expected %0d", low, RC);
        end
        send_byte(8'h11);
        repeat ($urandom_range(0, 3)) cycle();
        send_byte(8'h22);
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) cycle();
            send_byte(8'(i));
        end
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 3)) cycle();
            send_byte(8'hF0 + 8'(i));
        end
        repeat (3) cycle();
        checks++;
        if ({done, busy, error} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL gap_status: got done=%b busy=%b error=%b, expected 1 0 0", done, busy, error);
        end
        checks++;
        if (wa_q.size() != 8) begin
            errors++;
            $display("[TB] FAIL gap_count: got %0d writes, expected 8", wa_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== pix(i)) begin
                    errors++;
                    $display("[TB] FAIL gap_write%0d: got addr=%0d data=%h, expected %0d %h",
                             i, wa_q[i], wd_q[i], i, pix(i));
                end
            end
        end
    endtask

    task automatic test_short_file();
        int low;
        clear_writes();
        start_load(low);
        send_byte(8'hEE);
        send_byte(8'hEE);
        for (int i = 0; i < 10; i++) send_byte(8'(i));
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL short_before: got error=%b busy=%b, expected 0 1", error, busy);
        end
        fatstate = 3'd6;
        cycle();
        fatstate = 3'd0;
        checks++;
        if ({error, done, busy} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL short_status: got error=%b done=%b busy=%b, expected 1 0 0", error, done, busy);
        end
        send_byte(8'h0A);
        send_byte(8'h0B);
        repeat (2) cycle();
        checks++;
        if (wa_q.size() != 3) begin
            errors++;
            $display("[TB] FAIL short_count: got %0d writes, expected 3", wa_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== pix(i)) begin
                    errors++;
                    $display("[TB] FAIL short_write%0d: got addr=%0d data=%h, expected %0d %h",
                             i, wa_q[i], wd_q[i], i, pix(i));
                end
            end
        end
    endtask

    task automatic test_not_found();
        int low;
        clear_writes();
        start_load(low);
        send_byte(8'hEE);
        checks++;
        if (error !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nf_cleared: got error=%b done=%b, expected 0 0", error, done);
        end
        file_found = 1'b0;
        fatstate   = 3'd6;
        cycle();
        file_found = 1'b1;
        fatstate   = 3'd0;
        checks++;
        if ({error, busy} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL nf_status: got error=%b busy=%b, expected 1 0", error, busy);
        end
        repeat (2) cycle();
        checks++;
        if (wa_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL nf_writes: got %0d writes, expected 0", wa_q.size());
        end
    endtask

    task automatic test_restart();
        int low;
        clear_writes();
        start_load(low);
        send_byte(8'hEE);
        send_byte(8'hEE);
        for (int i = 0; i < 12; i++) send_byte(8'(i));
        start   = 1'b1;
        outreq  = 1'b1;
        outbyte = 8'hAA;
        cycle();
        start  = 1'b0;
        outreq = 1'b0;
        checks++;
        if ({sd_rst_n, busy, done, error} !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL restart_state: got sd_rst_n=%b busy=%b done=%b error=%b, expected 0 1 0 0",
                     sd_rst_n, busy, done, error);
        end
        wait_release(low);
        checks++;
        if (low != RC) begin
            errors++;
            $display("[TB] FAIL restart_rst_low: got %0d cycles, expected %0d", low, RC);
        end
        send_byte(8'h55);
        send_byte(8'h66);
        send_byte(8'h30);
        send_byte(8'h31);
        send_byte(8'h32);
        cycle();
        checks++;
        if (wa_q.size() != 5) begin
            errors++;
            $display("[TB] FAIL restart_count: got %0d writes, expected 5", wa_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wa_q[i] !== AW'(i) || wd_q[i] !== pix(i)) begin
                    errors++;
                    $display("[TB] FAIL restart_first%0d: got addr=%0d data=%h, expected %0d %h",
                             i, wa_q[i], wd_q[i], i, pix(i));
                end
            end
            checks++;
            if (wa_q[4] !== 3'd0 || wd_q[4] !== 24'h303132) begin
                errors++;
                $display("[TB] FAIL restart_reload: got addr=%0d data=%h, expected 0 303132", wa_q[4], wd_q[4]);
            end
        end
    endtask

    task automatic test_async_reset();
        int low;
        start_load(low);
        send_byte(8'hEE);
        send_byte(8'hEE);
        for (int i = 0; i < 3; i++) send_byte(8'(i + 8'h40));
        #2;
        rst_in = 1'b1;
        #1;
        checks++;
        if ({sd_rst_n, busy, done, error, wr_en} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("[TB] FAIL async_reset: got sd_rst_n=%b busy=%b done=%b error=%b wr_en=%b addr=%0d data=%h, expected all 0",
                     sd_rst_n, busy, done, error, wr_en, wr_addr, wr_data);
        end
        cycle();
        rst_in = 1'b0;
        cycle();
    endtask

    // Scenario sequence
    initial begin
        rst_in     = 1'b1;
        start      = 1'b0;
        file_found = 1'b1;
        fatstate   = 3'd0;
        outreq     = 1'b0;
        outbyte    = 8'h00;
        test_reset();
        test_full_load();
        test_gapped();
        test_short_file();
        test_not_found();
        test_restart();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
